// File: rtl/drf_io_pkg.sv
// ============================================================================
// Module   : drf_io_pkg
// Purpose  : Register-select encodings and index-width helper for drf_io_ports
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package drf_io_pkg;

  localparam logic [1:0] REG_DATA_IN  = 2'd0;
  localparam logic [1:0] REG_DATA_OUT = 2'd1;
  localparam logic [1:0] REG_CHG      = 2'd2;
  localparam logic [1:0] REG_MASK     = 2'd3;

  // A single-port build still needs a 1-bit index field in the address.
  function automatic int idx_width(input int n);
    if (n <= 1) return 1;
    else return $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/drf_io_channel.sv
// ============================================================================
// Module   : drf_io_channel
// Purpose  : One I/O port: input synchroniser, output latch, sticky change
//            flags and interrupt mask
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module drf_io_channel #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_pin,
  input  logic             i_armed,
  input  logic             i_wr_out,
  input  logic             i_wr_chg,
  input  logic             i_wr_mask,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic [WIDTH-1:0] o_port,
  output logic [WIDTH-1:0] o_din,
  output logic [WIDTH-1:0] o_chg,
  output logic [WIDTH-1:0] o_mask,
  output logic             o_irq_req
);

  logic [WIDTH-1:0] r_s1, r_s2, r_s3;
  logic [WIDTH-1:0] r_out, r_chg, r_mask;
  logic [WIDTH-1:0] w_set, w_clr;

  assign w_set = i_armed  ? (r_s2 ^ r_s3) : '0;
  assign w_clr = i_wr_chg ? i_wr_data     : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_s3   <= '0;
      r_out  <= '0;
      r_chg  <= '0;
      r_mask <= '0;
    end else begin
      r_s1  <= i_pin;
      r_s2  <= r_s1;
      r_s3  <= r_s2;
      // Clear is applied first so a coincident new change keeps its bit set.
      r_chg <= (r_chg & ~w_clr) | w_set;
      if (i_wr_out)  r_out  <= i_wr_data;
      if (i_wr_mask) r_mask <= i_wr_data;
    end
  end

  assign o_port    = r_out;
  assign o_din     = r_s2;
  assign o_chg     = r_chg;
  assign o_mask    = r_mask;
  assign o_irq_req = |(r_chg & r_mask);

endmodule

`default_nettype wire

// File: rtl/drf_io_ports.sv
// ============================================================================
// Module   : drf_io_ports
// Purpose  : N_PORTS x WIDTH I/O port block with registered CPU bus and irq
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module drf_io_ports
  import drf_io_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int N_PORTS = 2,
  localparam int IDX_W  = idx_width(N_PORTS),
  localparam int ADDR_W = IDX_W + 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_PORTS*WIDTH-1:0]   port_input,
  output logic [N_PORTS*WIDTH-1:0]   port_output,
  input  logic [ADDR_W-1:0]          addr,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic                       irq
);

  logic [1:0]       r_arm_cnt;
  logic             w_armed;
  logic [IDX_W-1:0] w_idx;
  logic [1:0]       w_sel;
  logic [WIDTH-1:0] w_din  [N_PORTS];
  logic [WIDTH-1:0] w_out  [N_PORTS];
  logic [WIDTH-1:0] w_chg  [N_PORTS];
  logic [WIDTH-1:0] w_mask [N_PORTS];
  logic [N_PORTS-1:0] w_irq_req;
  logic [WIDTH-1:0] w_rd_mux;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;
  logic             r_irq;

  assign w_idx   = addr[ADDR_W-1:2];
  assign w_sel   = addr[1:0];
  assign w_armed = (r_arm_cnt == 2'd3);

  // Holds off change detection while the synchroniser fills after reset.
  always_ff @(posedge clk) begin
    if (reset) r_arm_cnt <= 2'd0;
    else if (r_arm_cnt != 2'd3) r_arm_cnt <= r_arm_cnt + 2'd1;
  end

  for (genvar g = 0; g < N_PORTS; g++) begin : g_ch
    logic w_hit;
    assign w_hit = wr_en && (w_idx == IDX_W'(g));

    drf_io_channel #(.WIDTH(WIDTH)) u_ch (
      .clk       (clk),
      .reset     (reset),
      .i_pin     (port_input[g*WIDTH +: WIDTH]),
      .i_armed   (w_armed),
      .i_wr_out  (w_hit && (w_sel == REG_DATA_OUT)),
      .i_wr_chg  (w_hit && (w_sel == REG_CHG)),
      .i_wr_mask (w_hit && (w_sel == REG_MASK)),
      .i_wr_data (wr_data),
      .o_port    (w_out[g]),
      .o_din     (w_din[g]),
      .o_chg     (w_chg[g]),
      .o_mask    (w_mask[g]),
      .o_irq_req (w_irq_req[g])
    );

    assign port_output[g*WIDTH +: WIDTH] = w_out[g];
  end

  // Unmatched (out-of-range) indices fall through to zero.
  always_comb begin
    w_rd_mux = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (w_idx == IDX_W'(p)) begin
        case (w_sel)
          REG_DATA_IN:  w_rd_mux = w_din[p];
          REG_DATA_OUT: w_rd_mux = w_out[p];
          REG_CHG:      w_rd_mux = w_chg[p];
          default:      w_rd_mux = w_mask[p];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) r_rd_data <= w_rd_mux;
      r_irq <= |w_irq_req;
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign irq      = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_drf_io_ports.sv
// ============================================================================
// Module   : tb_drf_io_ports
// Purpose  : Directed bench for drf_io_ports (2-port and 3-port builds)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_drf_io_ports;

  typedef struct {
    logic [3:0] data;
    int         due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  // 2-port DUT
  logic [7:0]  pin_a;
  logic [7:0]  pout_a;
  logic [2:0]  addr_a;
  logic        wr_en_a, rd_en_a;
  logic [3:0]  wr_data_a, rd_data_a;
  logic        rd_valid_a, irq_a;
  exp_t        qa[$];

  // 3-port DUT (exercises out-of-range indices)
  logic [11:0] pin_b;
  logic [11:0] pout_b;
  logic [3:0]  addr_b;
  logic        wr_en_b, rd_en_b;
  logic [3:0]  wr_data_b, rd_data_b;
  logic        rd_valid_b, irq_b;
  exp_t        qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  drf_io_ports #(.WIDTH(4), .N_PORTS(2)) u_dut_a (
    .clk(clk), .reset(reset), .port_input(pin_a), .port_output(pout_a),
    .addr(addr_a), .wr_en(wr_en_a), .wr_data(wr_data_a), .rd_en(rd_en_a),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a), .irq(irq_a)
  );

  drf_io_ports #(.WIDTH(4), .N_PORTS(3)) u_dut_b (
    .clk(clk), .reset(reset), .port_input(pin_b), .port_output(pout_b),
    .addr(addr_b), .wr_en(wr_en_b), .wr_data(wr_data_b), .rd_en(rd_en_b),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .irq(irq_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input logic [2:0] a, input logic [3:0] d);
    addr_a = a; wr_data_a = d; wr_en_a = 1'b1;
    tick();
    wr_en_a = 1'b0;
  endtask

  task automatic rd_a(input logic [2:0] a, input logic [3:0] e);
    addr_a = a; rd_en_a = 1'b1;
    qa.push_back('{e, cyc + 1});
    tick();
    rd_en_a = 1'b0;
  endtask

  task automatic wr_b(input logic [3:0] a, input logic [3:0] d);
    addr_b = a; wr_data_b = d; wr_en_b = 1'b1;
    tick();
    wr_en_b = 1'b0;
  endtask

  task automatic rd_b(input logic [3:0] a, input logic [3:0] e);
    addr_b = a; rd_en_b = 1'b1;
    qb.push_back('{e, cyc + 1});
    tick();
    rd_en_b = 1'b0;
  endtask

  // Scoreboard: every rd_valid must match the oldest pending read, on time.
  always @(negedge clk) begin
    exp_t e;
    if (rd_valid_a) begin
      if (qa.size() == 0) chk("a_unexpected_valid", rd_valid_a, 0);
      else begin
        e = qa.pop_front();
        chk("a_rd_data", rd_data_a, e.data);
        chk("a_rd_cycle", cyc, e.due);
      end
    end else if (qa.size() > 0 && qa[0].due <= cyc) begin
      chk("a_missing_valid", rd_valid_a, 1);
      void'(qa.pop_front());
    end
    if (rd_valid_b) begin
      if (qb.size() == 0) chk("b_unexpected_valid", rd_valid_b, 0);
      else begin
        e = qb.pop_front();
        chk("b_rd_data", rd_data_b, e.data);
        chk("b_rd_cycle", cyc, e.due);
      end
    end else if (qb.size() > 0 && qb[0].due <= cyc) begin
      chk("b_missing_valid", rd_valid_b, 1);
      void'(qb.pop_front());
    end
  end

  initial begin
    reset = 1'b1;
    pin_a = 8'hA5; addr_a = '0; wr_en_a = 0; rd_en_a = 0; wr_data_a = '0;
    pin_b = '0;    addr_b = '0; wr_en_b = 0; rd_en_b = 0; wr_data_b = '0;
    tick(); tick();
    chk("rst_port_output", pout_a, 8'h00);
    chk("rst_rd_valid", rd_valid_a, 0);
    chk("rst_irq", irq_a, 0);
    chk("rst_rd_data", rd_data_a, 0);
    reset = 1'b0;
    repeat (5) tick();
    rd_a({1'b0, 2'd2}, 4'h0);
    rd_a({1'b1, 2'd2}, 4'h0);

    // Output register write and readback
    wr_a({1'b1, 2'd1}, 4'hC);
    chk("out_write", pout_a, 8'hC0);
    rd_a({1'b1, 2'd1}, 4'hC);
    tick();
    chk("rd_valid_one_cycle", rd_valid_a, 0);

    // Drop inputs to zero, then clear the resulting flags
    pin_a = 8'h00;
    repeat (4) tick();
    rd_a({1'b0, 2'd2}, 4'h5);
    rd_a({1'b1, 2'd2}, 4'hA);
    chk("irq_masked_off", irq_a, 0);
    wr_a({1'b0, 2'd2}, 4'hF);
    wr_a({1'b1, 2'd2}, 4'hF);
    rd_a({1'b0, 2'd2}, 4'h0);
    rd_a({1'b1, 2'd2}, 4'h0);

    // Change detect latency and irq
    wr_a({1'b0, 2'd3}, 4'h1);
    pin_a = 8'h03;
    rd_a({1'b0, 2'd0}, 4'h0);          // edge k
    rd_a({1'b0, 2'd2}, 4'h0);          // edge k+1
    chk("irq_k1", irq_a, 0);
    rd_a({1'b0, 2'd0}, 4'h3);          // edge k+2
    chk("irq_k2", irq_a, 0);
    rd_a({1'b0, 2'd2}, 4'h3);          // edge k+3
    chk("irq_k3", irq_a, 1);
    wr_a({1'b0, 2'd2}, 4'h1);
    chk("irq_after_w1c_edge", irq_a, 1);
    tick();
    chk("irq_cleared", irq_a, 0);
    rd_a({1'b0, 2'd2}, 4'h2);

    // Set wins over a coincident write-1-to-clear
    pin_a = 8'h07;
    tick();                            // edge k
    tick();                            // edge k+1
    wr_a({1'b0, 2'd2}, 4'h4);          // edge k+2
    rd_a({1'b0, 2'd2}, 4'h6);
    chk("irq_set_beats_clear", irq_a, 0);
    wr_a({1'b0, 2'd2}, 4'hF);
    rd_a({1'b0, 2'd3}, 4'h1);

    // Read/write collision returns the pre-write value
    wr_a({1'b0, 2'd1}, 4'h2);
    addr_a = {1'b0, 2'd1}; wr_data_a = 4'h9; wr_en_a = 1'b1; rd_en_a = 1'b1;
    qa.push_back('{4'h2, cyc + 1});
    tick();
    wr_en_a = 1'b0; rd_en_a = 1'b0;
    rd_a({1'b0, 2'd1}, 4'h9);
    chk("collision_out", pout_a, 8'hC9);

    // Three-port build: out-of-range index
    wr_b({2'd3, 2'd1}, 4'hF);
    chk("oor_write_ignored", pout_b, 12'h000);
    wr_b({2'd2, 2'd1}, 4'h5);
    chk("port2_write", pout_b, 12'h500);
    rd_b({2'd3, 2'd1}, 4'h0);
    rd_b({2'd2, 2'd1}, 4'h5);
    rd_b({2'd3, 2'd3}, 4'h0);
    tick();
    chk("b_valid_drop", rd_valid_b, 0);

    // Reset mid-operation cancels a pending read
    addr_a = {1'b1, 2'd1}; rd_en_a = 1'b1; reset = 1'b1;
    tick();
    rd_en_a = 1'b0;
    chk("midrst_rd_valid", rd_valid_a, 0);
    chk("midrst_port_output", pout_a, 8'h00);
    chk("midrst_rd_data", rd_data_a, 0);
    reset = 1'b0;
    tick(); tick();
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
